// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
package alu_mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MADD  = 4'd2;
  localparam logic [3:0] OP_MADDU = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_DIVU  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu_divider.sv
// Restoring divide core on unsigned magnitudes: load latches operands, each step retires one
// quotient bit; after WIDTH steps the quotient and remainder are final.
module alu_mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      if (w_trial[WIDTH]) begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end else begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_mdu_seq.sv
// Iterative MULT/MADD/DIV with HI/LO: done WIDTH+2 cycles after accept, MTHI/MTLO done next cycle.
// start ignored while busy, abort flushes CALC/FIX; divider present only with ALU_MDU_DIV_EN.
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [2*WIDTH-1:0] w_res;
  logic [WIDTH:0]     w_psum;
  logic               r_neg_p;
  logic               r_madd;
  logic               r_dbz;
  logic               r_mt_done;
  logic               w_accept;
  logic               w_div_op;
  logic               w_mt_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_div_op = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_mt_op  = (i_op == OP_MTHI) || (i_op == OP_MTLO);
  assign w_accept = i_start && (r_state == IDLE) && (i_op <= OP_MTLO);
  assign w_a_neg  = op_is_signed(i_op) && i_a[WIDTH-1];
  assign w_b_neg  = op_is_signed(i_op) && i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // Shift-add: multiplier sits in the low half of r_prod and drains out one bit per cycle.
  assign w_psum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_s  = r_neg_p ? -r_prod : r_prod;
  assign w_mul_res = w_prod_s + (r_madd ? {r_hi, r_lo} : '0);

`ifdef ALU_MDU_DIV_EN
  logic             r_is_div;
  logic             r_neg_r;
  logic             w_b_zero;
  logic             w_div_step;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo_s;
  logic [WIDTH-1:0] w_rem_s;

  assign w_b_zero   = (i_b == '0);
  assign w_div_step = (r_state == CALC) && r_is_div;
  assign w_quo_s    = r_neg_p ? -w_quo : w_quo;
  assign w_rem_s    = r_neg_r ? -w_rem : w_rem;
  assign w_res      = r_is_div ? {w_rem_s, w_quo_s} : w_mul_res;

  alu_mdu_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_accept),
    .i_step      (w_div_step),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );
`else
  assign w_res = w_mul_res;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_mt_op) begin
`ifdef ALU_MDU_DIV_EN
          w_next = (w_div_op && w_b_zero) ? DONE : CALC;
`else
          w_next = w_div_op ? DONE : CALC;
`endif
        end
      end
      CALC: begin
        if (i_abort)                            w_next = IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))    w_next = FIX;
      end
      FIX:     w_next = i_abort ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_neg_p   <= 1'b0;
      r_madd    <= 1'b0;
      r_dbz     <= 1'b0;
      r_mt_done <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else begin
      r_mt_done <= 1'b0;
      if (w_accept) begin
        r_cnt   <= '0;
        r_mcand <= w_a_mag;
        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
        r_neg_p <= w_a_neg ^ w_b_neg;
        r_madd  <= (i_op == OP_MADD) || (i_op == OP_MADDU);
        r_dbz   <= 1'b0;
        if (i_op == OP_MTHI) begin
          r_hi      <= i_a;
          r_mt_done <= 1'b1;
        end
        if (i_op == OP_MTLO) begin
          r_lo      <= i_a;
          r_mt_done <= 1'b1;
        end
`ifdef ALU_MDU_DIV_EN
        r_is_div <= w_div_op;
        r_neg_r  <= w_a_neg;
        if (w_div_op && w_b_zero) begin
          r_hi  <= i_a;
          r_lo  <= '1;
          r_dbz <= 1'b1;
        end
`endif
      end
      if (r_state == CALC) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_prod <= {w_psum, r_prod[WIDTH-1:1]};
      end
      // Writing on the FIX->DONE edge makes hi/lo valid in the same cycle as done.
      if ((r_state == FIX) && !i_abort) {r_hi, r_lo} <= w_res;
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE) || r_mt_done;
  assign o_div_by_zero = r_dbz && (r_state == DONE);
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq at WIDTH=32 and WIDTH=8; expectations come from a native-arithmetic model.
`timescale 1ns/1ps
module tb_alu_mdu_seq;

  logic        clk;
  logic        rst;
  logic        s32_start, s32_abort;
  logic [3:0]  s32_op;
  logic [31:0] s32_a, s32_b;
  logic        d32_busy, d32_done, d32_dbz;
  logic [31:0] d32_hi, d32_lo;
  logic        s8_start, s8_abort;
  logic [3:0]  s8_op;
  logic [7:0]  s8_a, s8_b;
  logic        d8_busy, d8_done, d8_dbz;
  logic [7:0]  d8_hi, d8_lo;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32, e8;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  alu_mdu_seq #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32_start), .i_op(s32_op), .i_a(s32_a), .i_b(s32_b),
    .i_abort(s32_abort), .o_busy(d32_busy), .o_done(d32_done), .o_div_by_zero(d32_dbz),
    .o_hi(d32_hi), .o_lo(d32_lo)
  );

  alu_mdu_seq #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_op(s8_op), .i_a(s8_a), .i_b(s8_b),
    .i_abort(s8_abort), .o_busy(d8_busy), .o_done(d8_done), .o_div_by_zero(d8_dbz),
    .o_hi(d8_hi), .o_lo(d8_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo,
                                output logic dbz, output int lat);
    logic [63:0] mw, ua, ub, p;
    longint      sa, sb;
`ifdef ALU_MDU_DIV_EN
    longint      q, r;
`endif
    mw  = (64'd1 << w) - 64'd1;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = longint'(ua);
    sb  = longint'(ub);
    if (a[w-1]) sa = sa - longint'(64'd1 << w);
    if (b[w-1]) sb = sb - longint'(64'd1 << w);
    dbz = 1'b0;
    lat = w + 2;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        if (op == 4'd0 || op == 4'd2) p = $unsigned(sa * sb);
        else                          p = ua * ub;
        if (op == 4'd2 || op == 4'd3) p = p + (({32'd0, hi} << w) | {32'd0, lo});
        hi = 32'((p >> w) & mw);
        lo = 32'(p & mw);
      end
      4'd4, 4'd5: begin
        lat = 1;
`ifdef ALU_MDU_DIV_EN
        if (b == 32'd0) begin
          hi  = a;
          lo  = 32'(mw);
          dbz = 1'b1;
        end else if (op == 4'd4) begin
          lat = w + 2;
          q   = sa / sb;
          r   = sa % sb;
          lo  = 32'($unsigned(q) & mw);
          hi  = 32'($unsigned(r) & mw);
        end else begin
          lat = w + 2;
          lo  = 32'(ua / ub);
          hi  = 32'(ua % ub);
        end
`endif
      end
      4'd6: begin hi = a; lat = 1; end
      4'd7: begin lo = a; lat = 1; end
      default: lat = 0;
    endcase
  endfunction

  // Called at the negedge where start is driven; acceptance happens on the next posedge.
  task automatic push_exp(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] h, l;
    logic        dz;
    int          lat;
    h = m_hi[w8];
    l = m_lo[w8];
    model(w8 ? 8 : 32, op, a, b, h, l, dz, lat);
    m_hi[w8] = h;
    m_lo[w8] = l;
    e.cyc = cyc + lat;
    e.hi  = h;
    e.lo  = l;
    e.dbz = dz;
    if (w8) q8.push_back(e);
    else    q32.push_back(e);
  endtask

  task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit with_abort, input bit expect_done);
    logic [31:0] am, bm;
    int          k = 0;
    am = w8 ? {24'd0, a[7:0]} : a;
    bm = w8 ? {24'd0, b[7:0]} : b;
    @(negedge clk);
    while ((w8 ? d8_busy : d32_busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("issue_idle", w8 ? d8_busy : d32_busy, 0);
    if (w8) begin
      s8_start = 1'b1; s8_op = op; s8_a = am[7:0]; s8_b = bm[7:0]; s8_abort = with_abort;
    end else begin
      s32_start = 1'b1; s32_op = op; s32_a = am; s32_b = bm; s32_abort = with_abort;
    end
    if (expect_done && !op[3]) push_exp(w8, op, am, bm);
    @(negedge clk);
    s32_start = 1'b0; s32_abort = 1'b0; s32_a = $urandom; s32_b = $urandom;
    s8_start  = 1'b0; s8_abort  = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((d32_busy || d8_busy || q32.size() != 0 || q8.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("drain_busy", {d32_busy, d8_busy}, 0);
    check_val("drain_pending", q32.size() + q8.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && d32_done) begin
      if (q32.size() == 0) check_val("d32_unexpected_done", d32_done, 0);
      else begin
        e32 = q32.pop_front();
        check_val("d32_done_cycle", cyc, e32.cyc);
        check_val("d32_hi", d32_hi, e32.hi);
        check_val("d32_lo", d32_lo, e32.lo);
        check_val("d32_dbz", d32_dbz, e32.dbz);
      end
    end
    if (!rst && d8_done) begin
      if (q8.size() == 0) check_val("d8_unexpected_done", d8_done, 0);
      else begin
        e8 = q8.pop_front();
        check_val("d8_done_cycle", cyc, e8.cyc);
        check_val("d8_hi", d8_hi, e8.hi);
        check_val("d8_lo", d8_lo, e8.lo);
        check_val("d8_dbz", d8_dbz, e8.dbz);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    s32_start = 1'b0; s32_abort = 1'b0; s32_op = 4'd0; s32_a = '0; s32_b = '0;
    s8_start  = 1'b0; s8_abort  = 1'b0; s8_op  = 4'd0; s8_a  = '0; s8_b  = '0;
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    @(negedge clk);
    check_val("rst_busy", d32_busy, 0);
    check_val("rst_done", d32_done, 0);
    check_val("rst_dbz", d32_dbz, 0);
    check_val("rst_hi", d32_hi, 0);
    check_val("rst_lo", d32_lo, 0);
    @(negedge clk);
    rst = 1'b0;

    // MULT -3*5 with busy window length
    issue(0, 4'd0, 32'hFFFFFFFD, 32'd5, 0, 1);
    n = 0;
    while (d32_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val("mult_busy_cycles", n, 34);
    check_val("mult_hi", d32_hi, 32'hFFFFFFFF);
    check_val("mult_lo", d32_lo, 32'hFFFFFFF1);

    // MTHI/MTLO then MADDU accumulate
    issue(0, 4'd6, 32'd1, 32'd0, 0, 1);
    check_val("mthi_busy", d32_busy, 0);
    issue(0, 4'd7, 32'hFFFFFFFF, 32'd0, 0, 1);
    issue(0, 4'd3, 32'd2, 32'd2, 0, 1);
    wait_idle();
    check_val("maddu_hi", d32_hi, 32'h00000002);
    check_val("maddu_lo", d32_lo, 32'h00000003);

    // signed division, MIN/-1 and divide by zero
    issue(0, 4'd4, 32'hFFFFFFF9, 32'd2, 0, 1);
    wait_idle();
`ifdef ALU_MDU_DIV_EN
    check_val("div_lo", d32_lo, 32'hFFFFFFFD);
    check_val("div_hi", d32_hi, 32'hFFFFFFFF);
`else
    check_val("div_off_lo", d32_lo, 32'h00000003);
    check_val("div_off_hi", d32_hi, 32'h00000002);
`endif
    issue(0, 4'd4, 32'h80000000, 32'hFFFFFFFF, 0, 1);
    wait_idle();
`ifdef ALU_MDU_DIV_EN
    check_val("divmin_lo", d32_lo, 32'h80000000);
    check_val("divmin_hi", d32_hi, 32'h00000000);
`endif
    issue(0, 4'd5, 32'h00001234, 32'd0, 0, 1);
    wait_idle();

    // start held high through a whole MULT; the extra MTHI requests must be dropped
    @(negedge clk);
    s32_start = 1'b1; s32_op = 4'd0; s32_a = 32'd7; s32_b = 32'hFFFFFFF7;
    push_exp(0, 4'd0, 32'd7, 32'hFFFFFFF7);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      s32_op = 4'd6;
      s32_a  = $urandom;
    end
    @(negedge clk);
    s32_start = 1'b0;
    wait_idle();
    check_val("hold_hi", d32_hi, m_hi[0]);
    check_val("hold_lo", d32_lo, m_lo[0]);

    // illegal op is ignored
    issue(0, 4'd9, 32'h12345678, 32'd3, 0, 1);
    check_val("illegal_busy", d32_busy, 0);

    // abort in CALC, abort in FIX, abort during DONE, abort+start while idle
    issue(0, 4'd1, 32'hCAFEF00D, 32'h12345, 0, 0);
    repeat (9) @(negedge clk);
    s32_abort = 1'b1;
    @(negedge clk);
    s32_abort = 1'b0;
    check_val("abort_calc_busy", d32_busy, 0);
    issue(0, 4'd1, 32'hCAFEF00D, 32'h54321, 0, 0);
    repeat (32) @(negedge clk);
    s32_abort = 1'b1;
    @(negedge clk);
    s32_abort = 1'b0;
    check_val("abort_fix_busy", d32_busy, 0);
    repeat (40) @(negedge clk);
    check_val("abort_hi", d32_hi, m_hi[0]);
    check_val("abort_lo", d32_lo, m_lo[0]);
    issue(0, 4'd0, 32'h0BADBEEF, 32'h00FACE00, 0, 1);
    repeat (33) @(negedge clk);
    s32_abort = 1'b1;
    @(negedge clk);
    s32_abort = 1'b0;
    wait_idle();
    issue(0, 4'd1, 32'h00010001, 32'h00030007, 1, 1);
    wait_idle();

    // reset mid-operation clears hi/lo at once
    issue(0, 4'd6, 32'h5A5A0000, 32'd0, 0, 1);
    issue(0, 4'd0, 32'h00001111, 32'h00002222, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_hi", d32_hi, 0);
    check_val("midrst_lo", d32_lo, 0);
    check_val("midrst_busy", d32_busy, 0);
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    @(negedge clk);
    rst = 1'b0;

    // randomised arithmetic at both widths
    for (int i = 0; i < 30; i++) begin
      issue(0, 4'($urandom_range(0, 5)), $urandom, (i % 8 == 3) ? 32'd0 : $urandom, 0, 1);
    end
    issue(1, 4'd4, 32'h80, 32'hFF, 0, 1);
    issue(1, 4'd5, 32'h37, 32'h00, 0, 1);
    for (int i = 0; i < 40; i++) begin
      issue(1, 4'($urandom_range(0, 5)), $urandom, (i % 10 == 4) ? 32'd0 : $urandom, 0, 1);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
